// File: rtl/cordic_defs.sv
// Shared constants and FSM encoding for the fixed-to-float converter.
package cordic_defs;

  localparam int unsigned FLOAT_BIAS = 127;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned MANT_W     = 23;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAbs   = 3'd1,
    StNorm  = 3'd2,
    StRound = 3'd3,
    StDone  = 3'd4
  } conv_state_e;

endpackage

// File: rtl/float_round.sv
// Combinational round-to-nearest-even packing of a normalised magnitude
// into an IEEE-754 single-precision word.
module float_round
  import cordic_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = WIDTH - 2,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             sign_i,
  input  logic [WIDTH-1:0] mag_i,
  input  logic [SW-1:0]    shift_i,
  output logic [31:0]      float_o
);

  localparam int EBase = int'(WIDTH) - 1 - int'(FRAC) + int'(FLOAT_BIAS);

  logic [MANT_W-1:0] mant;
  logic [MANT_W-1:0] mant_fin;
  logic [MANT_W:0]   mant_rnd;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic signed [8:0] exp_raw;
  logic signed [8:0] exp_fin;
  logic [1:0]        unused_bits;

  assign mant  = mag_i[WIDTH-2 -: MANT_W];
  assign guard = mag_i[WIDTH-2-MANT_W];

  generate
    if (WIDTH > 25) begin : g_sticky
      assign sticky = |mag_i[WIDTH-26:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  // mag_i[WIDTH-1] is the implicit leading one; exponent never leaves 1..254.
  assign unused_bits = {exp_fin[8], mag_i[WIDTH-1]};

  always_comb begin
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    exp_raw  = 9'(EBase) - 9'(shift_i);
    exp_fin  = exp_raw + 9'(mant_rnd[MANT_W]);
    mant_fin = mant_rnd[MANT_W] ? '0 : mant_rnd[MANT_W-1:0];
    float_o  = {sign_i, exp_fin[EXP_W-1:0], mant_fin};
  end

endmodule

// File: rtl/fixed_to_float.sv
// Multi-cycle signed fixed-point to IEEE-754 single conversion: absolute value,
// one-bit-per-cycle normalisation, then RNE rounding.
module fixed_to_float
  import cordic_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = WIDTH - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] fixed_in,
  output logic [31:0]      float_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     SW   = $clog2(WIDTH);
  localparam logic [SW-1:0]   SMax = SW'(WIDTH - 1);

  conv_state_e      state_q, state_d;
  logic [WIDTH-1:0] fixed_q, fixed_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [SW-1:0]    s_q, s_d;
  logic             sign_q, sign_d;
  logic [31:0]      float_q, float_d;
  logic [WIDTH-1:0] abs_mag;
  logic [31:0]      round_float;

  // Unary minus maps the most-negative input to 2^(WIDTH-1) as unsigned.
  assign abs_mag = fixed_q[WIDTH-1] ? -fixed_q : fixed_q;

  float_round #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .SW    (SW)
  ) u_round (
    .sign_i  (sign_q),
    .mag_i   (mag_q),
    .shift_i (s_q),
    .float_o (round_float)
  );

  always_comb begin
    state_d = state_q;
    fixed_d = fixed_q;
    mag_d   = mag_q;
    s_d     = s_q;
    sign_d  = sign_q;
    float_d = float_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          fixed_d = fixed_in;
          state_d = StAbs;
        end
      end
      StAbs: begin
        sign_d = fixed_q[WIDTH-1];
        mag_d  = abs_mag;
        s_d    = '0;
        if (abs_mag == '0) begin
          float_d = 32'h0000_0000;
          state_d = StDone;
        end else begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mag_q[WIDTH-1] || (s_q == SMax)) begin
          state_d = StRound;
        end else begin
          mag_d = mag_q << 1;
          s_d   = s_q + 1'b1;
        end
      end
      StRound: begin
        float_d = round_float;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      fixed_q <= '0;
      mag_q   <= '0;
      s_q     <= '0;
      sign_q  <= 1'b0;
      float_q <= '0;
    end else begin
      state_q <= state_d;
      fixed_q <= fixed_d;
      mag_q   <= mag_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      float_q <= float_d;
    end
  end

  assign float_out = float_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float: integer-arithmetic RNE reference,
// per-cycle compare of busy/done/float_out, directed and random stimulus.
module tb_fixed_to_float;

  localparam int W = 32;
  localparam int F = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] fixed_in;
  logic [31:0] float_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fixed_to_float #(
    .WIDTH (W),
    .FRAC  (F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .fixed_in  (fixed_in),
    .float_out (float_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact value x / 2^F rounded to single precision by integer RNE.
  function automatic void ref_conv(input logic [31:0] x, output logic [31:0] f,
                                   output int lat);
    longint a, q, r, half;
    int     p, e, sh;
    logic   s;
    s = x[31];
    a = s ? (longint'(64'h1_0000_0000) - longint'(x)) : longint'(x);
    if (a == 0) begin
      f   = 32'h0;
      lat = 1;
      return;
    end
    p = 31;
    while (((a >> p) & 1) == 0) p--;
    e = p - F + 127;
    if (p >= 23) begin
      sh = p - 23;
      q  = a >> sh;
      r  = a - (q << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (r > half || (r == half && (q % 2) == 1)) q++;
      end
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = a << (23 - p);
    end
    f   = {s, 8'(e), 23'(q)};
    lat = 3 + (31 - p);
  endfunction

  // Per-cycle compare against an abstract timeline of the expected conversion.
  initial begin : model
    int          n;
    int          busy_end;
    int          lat;
    logic [31:0] model_float;
    logic [31:0] pend_float;
    n           = 0;
    busy_end    = -1;
    model_float = 32'h0;
    pend_float  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_float", float_out, 32'h0);
        busy_end    = -1;
        model_float = 32'h0;
      end else begin
        if (n == busy_end) model_float = pend_float;
        check("busy", 32'(busy), 32'(n <= busy_end));
        check("done", 32'(done), 32'(n == busy_end));
        check("float_out", float_out, model_float);
        if (done) done_cnt++;
        if (valid_in && n > busy_end) begin
          ref_conv(fixed_in, pend_float, lat);
          busy_end = n + 1 + lat;
        end
      end
      n++;
    end
  end

  task automatic convert(input logic [31:0] x);
    logic [31:0] f;
    int          lat;
    ref_conv(x, f, lat);
    @(posedge clk);
    #1 valid_in = 1'b1;
    fixed_in = x;
    @(posedge clk);
    #1 valid_in = 1'b0;
    fixed_in = $urandom;
    repeat (lat) @(posedge clk);
  endtask

  logic [31:0] dir_x   [12] = '{32'h4000_0000, 32'h8000_0000, 32'h2000_0000, 32'h7FFF_FFFF,
                                32'h4000_0001, 32'hC000_0000, 32'h0000_0000, 32'h0000_0001,
                                32'h4000_0040, 32'h4000_00C0, 32'hFFFF_FFFF, 32'h7FFF_FF80};
  logic [31:0] dir_f   [12] = '{32'h3F80_0000, 32'hC000_0000, 32'h3F00_0000, 32'h4000_0000,
                                32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3080_0000,
                                32'h3F80_0000, 32'h3F80_0002, 32'hB080_0000, 32'h3FFF_FFFF};
  int          dir_lat [12] = '{4, 3, 5, 4, 4, 4, 1, 34, 4, 4, 34, 4};

  initial begin : stim
    logic [31:0] f;
    logic [31:0] x;
    int          lat;
    int          base;
    rst      = 1'b0;
    valid_in = 1'b0;
    fixed_in = 32'h0;
    #1;
    check("por_busy", 32'(busy), 32'h0);
    check("por_done", 32'(done), 32'h0);
    check("por_float", float_out, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      ref_conv(dir_x[i], f, lat);
      check("pin_model_float", f, dir_f[i]);
      check("pin_model_latency", 32'(lat), 32'(dir_lat[i]));
      convert(dir_x[i]);
    end

    for (int i = 0; i < 10000; i++) begin
      x = $urandom;
      if ($urandom_range(0, 15) == 0) x = 32'($signed(x) >>> $urandom_range(0, 31));
      convert(x);
    end

    // Abort a long conversion in NORM.
    @(posedge clk);
    #1 valid_in = 1'b1;
    fixed_in = 32'h0000_0001;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_float", float_out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    convert(32'h4000_0000);
    #1 check("after_abort_float", float_out, 32'h3F80_0000);

    // valid_in held high: one conversion per 6 cycles, one idle cycle between.
    repeat (2) @(posedge clk);
    base = done_cnt;
    @(posedge clk);
    #1 valid_in = 1'b1;
    fixed_in = 32'h4000_0000;
    repeat (60) @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (8) @(posedge clk);
    check("held_valid_dones", 32'(done_cnt - base), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
